fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Tracks the destination-register state of instructions in flight through EX and MEM.
- Registers the 2-bit select codes for the two 64-bit EX-stage ALU operand 4:1 muxes.
- Generates the decode stall and the EX bubble on load-use hazards.

Parameters:
- REG_BITS, 5, width of a register index.
- ZERO_REG, 31, index of XZR. Never a forwarding source and never a hazard.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  synchronous, active-high
- id_valid  input  1  decode stage holds a real instruction
- id_rn  input  REG_BITS  first source register of decode instruction
- id_rm  input  REG_BITS  second source register of decode instruction
- id_rn_used  input  1  decode instruction reads id_rn
- id_rm_used  input  1  decode instruction reads id_rm
- id_rd  input  REG_BITS  destination register of decode instruction
- id_regwrite  input  1  decode instruction writes id_rd
- id_memread  input  1  decode instruction is a load
- flush  input  1  taken branch resolved; squash decode instruction
- stall  output  1  combinational; hold PC and IF/ID register this cycle
- fwd_a  output  2  registered; select for EX operand A mux
- fwd_b  output  2  registered; select for EX operand B mux

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Select encoding for fwd_a/fwd_b:
  - 00 = register-file value.
  - 01 = EX/MEM ALU result (instruction one ahead).
  - 10 = MEM/WB write-back value (instruction two ahead).
  - 11 = reserved, never driven.
- Internal state, registered each cycle:
  - EX slot: ex_valid, ex_rd, ex_regwrite, ex_memread.
  - MEM slot: mem_valid, mem_rd, mem_regwrite.
- Reset: all valid bits 0, all rd fields 0, fwd_a = fwd_b = 00. stall reads 0 because ex_valid = 0.
- Hazard predicates:
  - hit_ex(r) = ex_valid & ex_regwrite & ex_rd==r & r!=ZERO_REG.
  - hit_mem(r) is the same predicate using the mem_* fields.
- stall = id_valid & ex_memread & ((id_rn_used & hit_ex(id_rn)) | (id_rm_used & hit_ex(id_rm))) & !flush.
- Advance when no stall and no flush:
  - EX slot <= decode fields, with valid = id_valid.
  - MEM slot <= EX slot.
  - fwd_a <= 01 if id_rn_used & hit_ex(id_rn); else 10 if id_rn_used & hit_mem(id_rn); else 00.
  - fwd_b is the same with id_rm/id_rm_used.
  - The younger instruction (EX hit) has priority over the older one (MEM hit).
- Stall cycle:
  - EX slot <= bubble (valid 0, regwrite 0, memread 0).
  - MEM slot <= EX slot.
  - fwd_a = fwd_b <= 00.
  - Next cycle the load is in MEM; the held instruction re-evaluates and gets 10. Exactly one stall cycle per load-use.
- Flush cycle: EX slot <= bubble, MEM slot <= EX slot, fwd <= 00. flush overrides stall; stall is deasserted during flush.
- No WB-slot tracking: the register file writes on the falling edge, so an instruction in WB is visible to a decode read in the same cycle.
- id_valid = 0 enters EX as a bubble. stall is never asserted for an invalid decode slot.
- Unused source operands (used = 0) never forward and never stall, even on a register match.
- reset asserted mid-stream: it overrides stall/flush and clears all slots on that edge. stall = 0 the cycle after.
- Latency: fwd_x is valid in the cycle the instruction occupies EX, one edge after its decode cycle.

Test Plan:
- Back-to-back dependency: ADD X1 (rd=1, regwrite) then SUB reading rn=1 on the next cycle -> when SUB is in EX, fwd_a=01, stall never asserted.
- Two-ahead dependency: ADD X2, NOP, then ORR reading rm=2 -> fwd_b=10 in ORR's EX cycle. Add a case with both older instructions writing X2 -> fwd_b=01 (youngest wins).
- Load-use: LDUR X3 then ADD reading rn=3 -> stall=1 for exactly one cycle and EX bubble inserted. ADD then enters EX with fwd_a=10, and stall=0 thereafter.
- XZR / unused operand: ADD writing X31 then consumer reading rn=31 -> fwd_a=00. Load to X4 then consumer with rm=4 but id_rm_used=0 -> stall=0, fwd_b=00.
- Flush during load-use: load X5, consumer reads X5, flush=1 in the same cycle -> stall=0, EX bubble, fwd=00. The load still reaches MEM.
- Reset mid-stream: assert reset while a load occupies EX -> next cycle all slots invalid, stall=0, fwd_a=fwd_b=00. A subsequent consumer of X5 gets 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use hazard control for the 5-stage pipeline.
// Tracks the destination registers of the instructions in EX and MEM.
module fwd_hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_rn_used,
    input  logic                id_rm_used,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b
);

    localparam logic [REG_BITS-1:0] ZREG = REG_BITS'(ZERO_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic                ex_valid;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_regwrite;
    logic                ex_memread;

    logic                mem_valid;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_regwrite;

    logic hit_ex_rn;
    logic hit_ex_rm;
    logic hit_mem_rn;
    logic hit_mem_rm;

    // XZR reads as constant zero, so it can never be a real producer
    function automatic logic slot_hit(input logic                v,
                                      input logic                wr,
                                      input logic [REG_BITS-1:0] rd,
                                      input logic [REG_BITS-1:0] r);
        return v && wr && (rd == r) && (r != ZREG);
    endfunction

    always_comb begin
        hit_ex_rn  = slot_hit(ex_valid,  ex_regwrite,  ex_rd,  id_rn);
        hit_ex_rm  = slot_hit(ex_valid,  ex_regwrite,  ex_rd,  id_rm);
        hit_mem_rn = slot_hit(mem_valid, mem_regwrite, mem_rd, id_rn);
        hit_mem_rm = slot_hit(mem_valid, mem_regwrite, mem_rd, id_rm);
        stall = id_valid && ex_memread && !flush &&
                ((id_rn_used && hit_ex_rn) || (id_rm_used && hit_ex_rm));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            fwd_a        <= SEL_RF;
            fwd_b        <= SEL_RF;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (flush || stall) begin
                // Bubble into EX; the held decode instruction re-evaluates next cycle
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a       <= SEL_RF;
                fwd_b       <= SEL_RF;
            end else begin
                ex_valid    <= id_valid;
                ex_rd       <= id_rd;
                ex_regwrite <= id_valid && id_regwrite;
                ex_memread  <= id_valid && id_memread;
                if (id_rn_used && hit_ex_rn)
                    fwd_a <= SEL_EX;
                else if (id_rn_used && hit_mem_rn)
                    fwd_a <= SEL_MEM;
                else
                    fwd_a <= SEL_RF;
                if (id_rm_used && hit_ex_rm)
                    fwd_b <= SEL_EX;
                else if (id_rm_used && hit_mem_rm)
                    fwd_b <= SEL_MEM;
                else
                    fwd_b <= SEL_RF;
            end
        end
    end

endmodule
